// File: rtl/plru_ctrl.sv
// plru_ctrl: tree pseudo-LRU replacement controller.
//
// Drives an external register array holding one PLRU word per set. After reset
// (and after a flush) it sweeps the array to zero, then accepts one hit/miss
// request per cycle. The accept cycle reads the set's word. The following cycle
// returns the touched way (the victim on a miss) and writes the updated word.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush / flush_done   clear request pulse / sweep-complete pulse
//   req_*                request: valid/ready handshake, set index, hit flag, way
//   rsp_valid, rsp_way   response strobe and touched way
//   arr_rindex           array read index (read data returns on arr_dataout)
//   arr_load, arr_windex, arr_datain   array write port
//   hit_count, miss_count   request statistics
//
// Optional feature: define PLRU_STATS_EN to build saturating hit/miss counters.
// Without it, both statistics outputs are tied to zero.
//
// States:
//   SWEEP | writing zero to set cnt_q, requests blocked
//   RUN   | accepting requests, stage B completes the previous one

module plru_ctrl #(
  parameter int  S_INDEX  = 3,
  parameter int  WAYS     = 4,
  localparam int W        = WAYS - 1,
  localparam int L        = $clog2(WAYS),
  localparam int NUM_SETS = 2 ** S_INDEX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  output logic               flush_done,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [S_INDEX-1:0] req_index,
  input  logic               req_hit,
  input  logic [L-1:0]       req_way,
  output logic               rsp_valid,
  output logic [L-1:0]       rsp_way,
  output logic [S_INDEX-1:0] arr_rindex,
  input  logic [W-1:0]       arr_dataout,
  output logic               arr_load,
  output logic [S_INDEX-1:0] arr_windex,
  output logic [W-1:0]       arr_datain,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);

  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [S_INDEX-1:0] cnt_q, cnt_d;
  logic               b_valid_q, b_valid_d;
  logic [S_INDEX-1:0] b_index_q, b_index_d;
  logic               b_hit_q, b_hit_d;
  logic [L-1:0]       b_way_q, b_way_d;
  logic [W-1:0]       b_bits_q, b_bits_d;

  logic               accept;
  logic               load_int;
  logic [L-1:0]       b_sel_way;
  logic [W-1:0]       b_new_bits;

  // Walk from the root; each node bit selects the upper (1) or lower (0) half,
  // so the bit read at each level is the next way-index bit, MSB first.
  function automatic logic [L-1:0] pick_victim(input logic [W-1:0] bits);
    logic [L-1:0] w;
    logic [W-1:0] sh;
    int           node;
    w    = '0;
    node = 0;
    for (int lvl = 0; lvl < L; lvl++) begin
      sh = bits >> node;
      w  = {w[L-2:0], sh[0]};
      node = sh[0] ? 2 * node + 2 : 2 * node + 1;
    end
    return w;
  endfunction

  // Every node on the path of way w is set to point into the other half.
  function automatic logic [W-1:0] touch(input logic [W-1:0] bits,
                                         input logic [L-1:0] w);
    logic [W-1:0] nb;
    logic [L-1:0] ws;
    logic         dir;
    int           node;
    nb   = bits;
    node = 0;
    for (int lvl = 0; lvl < L; lvl++) begin
      ws  = w >> (L - 1 - lvl);
      dir = ws[0];
      if (dir) nb = nb & ~(W'(1) << node);
      else     nb = nb | (W'(1) << node);
      node = dir ? 2 * node + 2 : 2 * node + 1;
    end
    return nb;
  endfunction

  // A request arriving with flush is refused so that no stage B op is left
  // pending when the sweep begins.
  assign req_ready  = (state_q == ST_RUN) & ~flush;
  assign accept     = req_valid & req_ready;
  assign arr_rindex = req_index;

  assign b_sel_way  = b_hit_q ? b_way_q : pick_victim(b_bits_q);
  assign b_new_bits = touch(b_bits_q, b_sel_way);

  assign rsp_valid  = b_valid_q;
  assign rsp_way    = b_valid_q ? b_sel_way : '0;
  assign arr_load   = load_int & ~rst;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    b_valid_d  = 1'b0;
    b_index_d  = b_index_q;
    b_hit_d    = b_hit_q;
    b_way_d    = b_way_q;
    b_bits_d   = b_bits_q;
    flush_done = 1'b0;
    load_int   = 1'b0;
    arr_windex = b_index_q;
    arr_datain = b_new_bits;
    case (state_q)
      ST_SWEEP: begin
        load_int   = 1'b1;
        arr_windex = cnt_q;
        arr_datain = '0;
        cnt_d      = cnt_q + S_INDEX'(1);
        if (cnt_q == S_INDEX'(NUM_SETS - 1)) begin
          flush_done = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: begin
        load_int = b_valid_q;
        if (accept) begin
          b_valid_d = 1'b1;
          b_index_d = req_index;
          b_hit_d   = req_hit;
          b_way_d   = req_way;
          b_bits_d  = arr_dataout;
        end
        if (flush) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_SWEEP;
      cnt_q     <= '0;
      b_valid_q <= 1'b0;
      b_index_q <= '0;
      b_hit_q   <= 1'b0;
      b_way_q   <= '0;
      b_bits_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      b_valid_q <= b_valid_d;
      b_index_q <= b_index_d;
      b_hit_q   <= b_hit_d;
      b_way_q   <= b_way_d;
      b_bits_q  <= b_bits_d;
    end
  end

`ifdef PLRU_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept) begin
      if (req_hit && (hit_cnt_q != '1))    hit_cnt_d  = hit_cnt_q + 32'd1;
      if (!req_hit && (miss_cnt_q != '1))  miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_plru_ctrl.sv
module tb_plru_ctrl;
  localparam int S    = 3;
  localparam int WAYS = 4;
  localparam int W    = WAYS - 1;
  localparam int L    = 2;
  localparam int N    = 8;
  localparam int VW   = 2 + L + S + W;

  logic         clk = 1'b0;
  logic         rst, flush, flush_done, req_valid, req_ready, req_hit;
  logic         rsp_valid, arr_load;
  logic [S-1:0] req_index, arr_rindex, arr_windex;
  logic [L-1:0] req_way, rsp_way;
  logic [W-1:0] arr_dataout, arr_datain;
  logic [31:0]  hit_count, miss_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  plru_ctrl #(.S_INDEX(S), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_done(flush_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_hit(req_hit), .req_way(req_way), .rsp_valid(rsp_valid),
    .rsp_way(rsp_way), .arr_rindex(arr_rindex), .arr_dataout(arr_dataout),
    .arr_load(arr_load), .arr_windex(arr_windex), .arr_datain(arr_datain),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Register array with same-cycle write-to-read forwarding.
  logic [W-1:0] mem [N];
  always @(posedge clk) if (arr_load) mem[arr_windex] <= arr_datain;
  assign arr_dataout = (arr_load && arr_windex == arr_rindex) ? arr_datain : mem[arr_rindex];

  // Reference model: per set, one 0/1 entry per tree node.
  int tr [N][W];
  int m_hits, m_misses;
  bit pend;
  logic [L-1:0] pend_way;
  logic [S-1:0] pend_idx;
  logic [W-1:0] pend_bits;

  logic [VW-1:0] obs_vec, exp_vec;
  logic          obs_ready;
  logic [S-1:0]  obs_rindex;
  logic [L-1:0]  obs_way;
  logic [W-1:0]  obs_datain;

  bit           sw_ready [N];
  bit           sw_load  [N];
  bit           sw_done  [N];
  logic [S-1:0] sw_windex [N];
  logic [W-1:0] sw_datain [N];
  bit           sw_ready_after;

  function automatic int ref_victim(int s);
    int lo = 0, hi = WAYS, node = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (tr[s][node] != 0) begin lo = mid; node = 2 * node + 2; end
      else begin hi = mid; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  task automatic ref_touch(int s, int w);
    int lo = 0, hi = WAYS, node = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin tr[s][node] = 1; hi = mid; node = 2 * node + 1; end
      else begin tr[s][node] = 0; lo = mid; node = 2 * node + 2; end
    end
  endtask

  function automatic logic [W-1:0] ref_word(int s);
    logic [W-1:0] v = '0;
    for (int n = 0; n < W; n++) v[n] = (tr[s][n] != 0);
    return v;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < N; s++)
      for (int n = 0; n < W; n++) tr[s][n] = 0;
    pend = 0;
  endtask

  // One RUN cycle: drive a request, sample outputs at negedge, advance model.
  task automatic drive_cycle(input bit v, input int idx, input bit hit, input int way);
    int w;
    req_valid = v;
    req_index = S'(idx);
    req_hit   = hit;
    req_way   = L'(way);
    @(negedge clk);
    obs_vec    = {rsp_valid, arr_load, rsp_valid ? {rsp_way, arr_windex, arr_datain} : {(L+S+W){1'b0}}};
    exp_vec    = {pend, pend, pend ? {pend_way, pend_idx, pend_bits} : {(L+S+W){1'b0}}};
    obs_ready  = req_ready;
    obs_rindex = arr_rindex;
    obs_way    = rsp_way;
    obs_datain = arr_datain;
    if (v && req_ready) begin
      w = hit ? way : ref_victim(idx);
      ref_touch(idx, w);
      if (hit) m_hits++; else m_misses++;
      pend      = 1;
      pend_way  = L'(w);
      pend_idx  = S'(idx);
      pend_bits = ref_word(idx);
    end else begin
      pend = 0;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Records num_sets sweep cycles plus req_ready on the following cycle.
  task automatic run_sweep();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      sw_ready[i]  = req_ready;
      sw_load[i]   = arr_load;
      sw_done[i]   = flush_done;
      sw_windex[i] = arr_windex;
      sw_datain[i] = arr_datain;
      @(posedge clk); #1;
    end
    @(negedge clk);
    sw_ready_after = req_ready;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_index = '0; req_hit = 1'b0; req_way = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({arr_load, req_ready, rsp_valid, rsp_way, flush_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got load=%b ready=%b rsp=%b way=%0d done=%b, want all 0",
               arr_load, req_ready, rsp_valid, rsp_way, flush_done);
    end
    checks++;
    if ({hit_count, miss_count} !== 64'd0) begin
      failures++;
      $display("FAIL reset_stats got %0d/%0d want 0/0", hit_count, miss_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear(); m_hits = 0; m_misses = 0;
    run_sweep();
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({sw_ready[i], sw_load[i], sw_windex[i], sw_datain[i], sw_done[i]} !==
          {1'b0, 1'b1, S'(i), {W{1'b0}}, (i == N - 1)}) begin
        failures++;
        $display("FAIL reset_sweep%0d got ready=%b load=%b windex=%0d datain=%b done=%b want 0 1 %0d 000 %b",
                 i, sw_ready[i], sw_load[i], sw_windex[i], sw_datain[i], sw_done[i], i, i == N - 1);
      end
    end
    checks++;
    if (sw_ready_after !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after got %b want 1", sw_ready_after);
    end
  endtask

  task automatic test_miss_forward();
    drive_cycle(1, 2, 0, 0);
    checks++;
    if ({obs_ready, obs_rindex} !== {1'b1, 3'd2}) begin
      failures++;
      $display("FAIL fwd_accept got ready=%b rindex=%0d want 1 2", obs_ready, obs_rindex);
    end
    drive_cycle(1, 2, 0, 0);
    checks++;
    if (obs_vec !== exp_vec || obs_way !== 2'd0 || obs_datain !== 3'b011) begin
      failures++;
      $display("FAIL fwd_first got vec=%h way=%0d data=%b want vec=%h way=0 data=011", obs_vec, obs_way, obs_datain, exp_vec);
    end
    drive_cycle(0, 0, 0, 0);
    checks++;
    if (obs_vec !== exp_vec || obs_way !== 2'd2 || obs_datain !== 3'b110 || arr_windex !== 3'd2) begin
      failures++;
      $display("FAIL fwd_second got vec=%h way=%0d data=%b want vec=%h way=2 data=110", obs_vec, obs_way, obs_datain, exp_vec);
    end
  endtask

  task automatic test_hit();
    drive_cycle(1, 5, 1, 3);
    drive_cycle(1, 5, 0, 0);
    checks++;
    if (obs_vec !== exp_vec || obs_way !== 2'd3 || obs_datain !== 3'b000) begin
      failures++;
      $display("FAIL hit_way3 got vec=%h way=%0d data=%b want vec=%h way=3 data=000", obs_vec, obs_way, obs_datain, exp_vec);
    end
    drive_cycle(0, 0, 0, 0);
    checks++;
    if (obs_vec !== exp_vec || obs_way !== 2'd0 || obs_datain !== 3'b011) begin
      failures++;
      $display("FAIL hit_then_miss got vec=%h way=%0d data=%b want vec=%h way=0 data=011", obs_vec, obs_way, obs_datain, exp_vec);
    end
  endtask

  task automatic test_flush();
    drive_cycle(1, 1, 0, 0);
    flush = 1'b1;
    @(negedge clk);
    obs_vec = {rsp_valid, arr_load, rsp_valid ? {rsp_way, arr_windex, arr_datain} : {(L+S+W){1'b0}}};
    exp_vec = {pend, pend, pend ? {pend_way, pend_idx, pend_bits} : {(L+S+W){1'b0}}};
    checks++;
    if (obs_vec !== exp_vec || obs_vec !== {2'b11, 2'd0, 3'd1, 3'b011} || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_stage_b got vec=%h ready=%b want vec=%h ready=0", obs_vec, req_ready, exp_vec);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    run_sweep();
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({sw_ready[i], sw_load[i], sw_windex[i], sw_datain[i], sw_done[i]} !==
          {1'b0, 1'b1, S'(i), {W{1'b0}}, (i == N - 1)}) begin
        failures++;
        $display("FAIL flush_sweep%0d got ready=%b load=%b windex=%0d datain=%b done=%b",
                 i, sw_ready[i], sw_load[i], sw_windex[i], sw_datain[i], sw_done[i]);
      end
    end
    checks++;
    if (sw_ready_after !== 1'b1) begin
      failures++;
      $display("FAIL flush_ready_after got %b want 1", sw_ready_after);
    end
    drive_cycle(1, 1, 0, 0);
    drive_cycle(0, 0, 0, 0);
    checks++;
    if (obs_vec !== exp_vec || obs_way !== 2'd0) begin
      failures++;
      $display("FAIL flush_then_miss got vec=%h way=%0d want vec=%h way=0", obs_vec, obs_way, exp_vec);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1, 3, 0, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, arr_load} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_discard got rsp=%b load=%b want 0 0", rsp_valid, arr_load);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear(); m_hits = 0; m_misses = 0;
    run_sweep();
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({sw_ready[i], sw_load[i], sw_windex[i], sw_done[i]} !== {1'b0, 1'b1, S'(i), (i == N - 1)}) begin
        failures++;
        $display("FAIL midreset_sweep%0d got ready=%b load=%b windex=%0d done=%b",
                 i, sw_ready[i], sw_load[i], sw_windex[i], sw_done[i]);
      end
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_h, exp_m;
    drive_cycle(1, 0, 1, 1);
    drive_cycle(1, 4, 0, 0);
    drive_cycle(1, 4, 1, 2);
    drive_cycle(1, 6, 1, 0);
    drive_cycle(1, 7, 0, 0);
    drive_cycle(0, 0, 0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    run_sweep();
`ifdef PLRU_STATS_EN
    exp_h = 32'd3; exp_m = 32'd2;
`else
    exp_h = 32'd0; exp_m = 32'd0;
`endif
    checks++;
    if (hit_count !== exp_h || miss_count !== exp_m) begin
      failures++;
      $display("FAIL stats_after_flush got hits=%0d misses=%0d want %0d %0d", hit_count, miss_count, exp_h, exp_m);
    end
  endtask

  task automatic test_random();
    int idx, last;
    bit v, hit;
    int bad;
    logic [31:0] exp_h, exp_m;
    last = 0;
    bad  = 0;
    for (int c = 0; c < 300; c++) begin
      v   = ($urandom % 4) != 0;
      idx = ($urandom % 3 == 0) ? last : int'($urandom_range(0, N - 1));
      hit = $urandom % 2;
      drive_cycle(v, idx, hit, int'($urandom_range(0, WAYS - 1)));
      last = idx;
      checks++;
      if (obs_vec !== exp_vec || obs_ready !== 1'b1 || obs_rindex !== S'(idx)) begin
        failures++;
        if (bad < 10)
          $display("FAIL rand_cycle%0d got vec=%h ready=%b rindex=%0d want vec=%h ready=1 rindex=%0d",
                   c, obs_vec, obs_ready, obs_rindex, exp_vec, idx);
        bad++;
      end
    end
    drive_cycle(0, 0, 0, 0);
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL rand_drain got vec=%h want %h", obs_vec, exp_vec);
    end
`ifdef PLRU_STATS_EN
    exp_h = 32'(m_hits); exp_m = 32'(m_misses);
`else
    exp_h = 32'd0; exp_m = 32'd0;
`endif
    checks++;
    if (hit_count !== exp_h || miss_count !== exp_m) begin
      failures++;
      $display("FAIL rand_stats got hits=%0d misses=%0d want %0d %0d", hit_count, miss_count, exp_h, exp_m);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_miss_forward();
    test_hit();
    test_flush();
    test_reset_mid();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/plru_ctrl.md
# plru_ctrl

Pseudo-LRU replacement controller for the set-associative caches; it is the client that drives a register array holding one tree-PLRU word per set. It accepts hit/miss requests, reads the set's PLRU bits, returns the victim way on a miss, and writes back updated bits one cycle later. It zeroes the whole array after reset and on a flush.

## Interface
- s_index, 3: set index width; num_sets = 2**s_index
- ways, 4: associativity, power of two ≥ 2; tree width W = ways-1; way width L = log2(ways)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  single-cycle pulse requesting a full array clear
- flush_done  out  1  one-cycle pulse when a sweep completes
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_index  in  s_index  set
- req_hit  in  1  1 = touch req_way; 0 = miss, select and touch a victim
- req_way  in  L  way touched on hit (ignored on miss)
- rsp_valid  out  1  response strobe
- rsp_way  out  L  way touched (victim on miss, req_way on hit)
- arr_rindex  out  s_index  array read index
- arr_dataout  in  W  array read data (combinational)
- arr_load  out  1  array write enable
- arr_windex  out  s_index  array write index
- arr_datain  out  W  array write data
- hit_count, miss_count  out  32 each  statistics (see Configuration)

## Operation
- Tree: node k has children 2k+1 (lower half) and 2k+2 (upper half); bit 0 means victim is in the lower half. Victim = walk from node 0 following bits. Touching way w sets every node on its path to point away from w; other bits are unchanged.
- ways=4: bit0 root, bit1 ways 0/1, bit2 ways 2/3. Touch way0 → b0=1,b1=1; way1 → b0=1,b1=0; way2 → b0=0,b2=1; way3 → b0=0,b2=0.
- FSM states SWEEP, RUN. rst → SWEEP with counter 0.
- SWEEP: arr_load=1, arr_windex=counter, arr_datain=0, counter++ each cycle; req_ready=0. On the cycle the counter equals num_sets-1, pulse flush_done and go to RUN next cycle.
- RUN: req_ready=1. Stage A (accept cycle): arr_rindex=req_index; register index, hit, way and arr_dataout into stage B. Stage B (next cycle): compute the way and the new bits; arr_load=1, arr_windex=stage-B index, arr_datain=new bits; rsp_valid=1.
- Same-index back-to-back requests: stage A reads the index being written by stage B. The array forwards same-cycle write data to its read port; the block relies on this and has no internal bypass.
- flush in RUN: any valid stage B completes its write and response that cycle; SWEEP starts on the next cycle. flush during SWEEP is ignored.
- When neither SWEEP nor stage B is active, arr_load=0. arr_rindex=req_index whenever not in SWEEP.

## Timing
- Reset values: state SWEEP, counter 0, stage B invalid, rsp_valid 0, rsp_way 0, flush_done 0, counters 0. arr_load=0 while rst is high.
- Sweep takes exactly num_sets cycles. req_ready rises on the cycle after flush_done.
- Response latency is 1 cycle after acceptance. Throughput is 1 request per cycle. There is no backpressure on rsp.
- Reset asserted mid-operation discards stage B (no write, no response) and restarts the sweep.

## Configuration
- PLRU_STATS_EN defined: hit_count and miss_count increment on each accepted hit or miss request and saturate at 2^32-1. A flush does not clear them; only rst does.
- PLRU_STATS_EN undefined: no counter registers; both outputs are tied to 0.

## Test plan
- Reset release, s_index=3: req_ready=0 for 8 cycles, arr_load=1 with windex 0..7 and datain 0, flush_done pulses with windex=7, req_ready=1 next cycle.
- Miss set 2 (bits 000): rsp_way=0 one cycle later, write 3'b011 to set 2. An immediately following miss on set 2 (relies on forwarding): rsp_way=2, write 3'b110.
- Hit set 5 on way 3 after reset: rsp_way=3, write 3'b000. Then a miss on set 5: rsp_way=0.
- Miss set 1 accepted, then flush the next cycle: stage B writes set 1 and rsp_valid=1, then an 8-cycle sweep, then a miss on set 1 returns way 0.
- Reset asserted while stage B is valid: no rsp_valid, and a sweep restarts from windex 0.
- With PLRU_STATS_EN: 3 hits and 2 misses give hit_count=3 and miss_count=2, which survive a flush. Without it, both read 0.
